hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 109 ++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard for a VLIW decode stage: per-register latency
// down-counters drive RAW/WAW stall decisions for whole issue bundles.
module hazard_scoreboard #(
    parameter  int NUM_LANES = 4,
    parameter  int NUM_REGS  = 32,
    parameter  int MAX_LAT   = 3,
    localparam int LAT_W     = $clog2(MAX_LAT + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              dc_valid,
    input  logic [NUM_LANES-1:0][4:0]         dc_rs1,
    input  logic [NUM_LANES-1:0][4:0]         dc_rs2,
    input  logic [NUM_LANES-1:0][4:0]         dc_rd,
    input  logic [NUM_LANES-1:0]              dc_we,
    input  logic [NUM_LANES-1:0][LAT_W-1:0]   dc_lat,
    input  logic                              flush,
    output logic                              stall_out,
    output logic                              stall_raw,
    output logic                              stall_waw,
    output logic [NUM_REGS-1:0]               busy_mask,
    output logic                              dup_rd_err
);

    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LAT);

    logic [LAT_W-1:0] cnt     [NUM_REGS];
    logic [LAT_W-1:0] cnt_nxt [NUM_REGS];
    logic [LAT_W-1:0] lat_c   [NUM_LANES];
    logic             raw_hit;
    logic             waw_hit;
    logic             dup_hit;
    logic             issue;

    // busy_mask depends on registered counters only, so stalls never see dc_* twice.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_mask[r] = (cnt[r] != '0);
        end
    end

    function automatic logic reg_busy(input logic [4:0] r, input logic [NUM_REGS-1:0] mask);
        return (r != 5'd0) && (int'(r) < NUM_REGS) && mask[r];
    endfunction

    // NOTE: every signal assigned in always_comb gets a default first; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        raw_hit = 1'b0;
        waw_hit = 1'b0;
        dup_hit = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            lat_c[l] = (dc_lat[l] > LAT_MAX) ? LAT_MAX : dc_lat[l];
            if (reg_busy(dc_rs1[l], busy_mask) || reg_busy(dc_rs2[l], busy_mask)) begin
                raw_hit = 1'b1;
            end
            if (dc_we[l] && reg_busy(dc_rd[l], busy_mask)) begin
                waw_hit = 1'b1;
            end
            for (int j = l + 1; j < NUM_LANES; j++) begin
                if (dc_we[l] && dc_we[j] && (dc_rd[l] == dc_rd[j]) && (dc_rd[l] != 5'd0)) begin
                    dup_hit = 1'b1;
                end
            end
        end
    end

    // Hazards are checked only against pre-bundle state, so writes inside the
    // bundle never stall readers in the same bundle.
    assign stall_raw = rst_n & dc_valid & raw_hit;
    assign stall_waw = rst_n & dc_valid & waw_hit;
    assign stall_out = (stall_raw | stall_waw) & ~flush;
    assign issue     = dc_valid & ~stall_out & ~flush;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_nxt[r] = (cnt[r] != '0) ? cnt[r] - LAT_W'(1) : '0;
        end
        // Ascending lane order lets the highest-numbered lane win a duplicate rd.
        if (issue) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (dc_we[l] && (dc_rd[l] != 5'd0) && (int'(dc_rd[l]) < NUM_REGS)
                    && (lat_c[l] != '0)) begin
                    cnt_nxt[dc_rd[l]] = lat_c[l];
                end
            end
        end
        cnt_nxt[0] = '0;
    end

    // NOTE: state updates use non-blocking assignments so every counter sees
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            // NOTE: the counter array is a bank of flops, not a RAM, so it is
            // cleared on reset; pending entries must not survive it.
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
            dup_rd_err <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
            dup_rd_err <= issue & dup_hit;
        end
    end

endmodule
